seg7_scan_scheduler: RTL and testbench
======================================

// Module: seg7_scan_scheduler
// PURPOSE
//  Time-shares one external seg7 decoder among NUM_DIGITS digit positions.
//  Holds one active frame of digit codes and scans it one digit per slot, with a blanking gap between slots to
//  avoid ghosting. New frames arrive through a valid/ready port into a one-entry shadow buffer. The shadow is
//  committed only at a frame boundary, so a frame is never shown torn.
//  Sits between the digit-value producers (counters, ui_in logic) and the seg7 decoder / uo_out pins.
// PARAMETERS
//  NUM_DIGITS    4     digit positions scanned, >=1
//  SHOW_CYCLES   10000 clk cycles a digit is driven per slot, >=1
//  BLANK_CYCLES  16    clk cycles all digit enables are low before each slot, >=1
// PORTS
//  clk        in   1               system clock
//  rst        in   1               reset: asynchronous, active-high
//  en         in   1               scan enable; 0 = idle, display dark
//  wr_valid   in   1               frame offered on wr_data/wr_dp
//  wr_ready   out  1               shadow buffer empty; write accepted when wr_valid & wr_ready
//  wr_data    in   4*NUM_DIGITS    packed codes; digit i in [4i+3:4i]
//  wr_dp      in   NUM_DIGITS      decimal point per digit
//  seg_digit  out  4               code of the current digit, to the seg7 decoder
//  seg_dp     out  1               decimal point of the current digit
//  digit_en   out  NUM_DIGITS      one-hot active-high digit select; all zero in IDLE/BLANK
//  digit_idx  out  clog2(N),min 1  index of the current slot
//  frame_done out  1               1-cycle pulse on the last cycle of the last digit's SHOW
// BEHAVIOUR
//  - Every output is a register, or a decode of registers only. No combinational path from inputs to outputs.
//  - Reset values: state=IDLE, idx=0, timer=0, active=0, shadow=0, pending=0.
//    Outputs: digit_en=0, seg_digit=0, seg_dp=0, frame_done=0, wr_ready=1.
//  - FSM states: IDLE, BLANK, SHOW.
//      IDLE -> BLANK when en=1. idx=0, timer is loaded.
//      BLANK -> SHOW after exactly BLANK_CYCLES cycles.
//      SHOW -> BLANK after exactly SHOW_CYCLES cycles. idx increments and wraps to 0 after NUM_DIGITS-1.
//      Any state -> IDLE on the clock after en=0. idx and timer clear; no frame_done pulse.
//  - Latency: en sampled 1 at edge t gives digit_en[0]=1 from edge t+1+BLANK_CYCLES.
//    Frame period = NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles.
//  - In SHOW: digit_en = onehot(idx), seg_digit = active[idx], seg_dp = active_dp[idx].
//    In BLANK/IDLE: digit_en=0, and seg_digit/seg_dp hold their last values.
//  - frame_end = SHOW & timer terminal & idx==NUM_DIGITS-1. frame_done = frame_end.
//  - Write handshake:
//      wr_ready = !pending.
//      On wr_valid & wr_ready: shadow <= {wr_data,wr_dp}, pending <= 1.
//      wr_valid while pending is ignored; the producer holds its data until it is accepted.
//  - Commit when pending & (state==IDLE | frame_end): active <= shadow, pending <= 0.
//    Because capture needs pending=0 and commit needs pending=1, they never occur in the same cycle.
//  - A write accepted mid-frame takes effect from digit 0 of the next frame.
//    A write accepted in IDLE commits on the following edge.
//  - NUM_DIGITS=1: every SHOW end is a frame_end, and idx stays 0.
//  - rst asserted at any time forces reset values immediately, without waiting for a clock edge.
// STRUCTURE
//  - seg7_pkg (shared): state encodings SCAN_IDLE/SCAN_BLANK/SCAN_SHOW, and DIGIT_W=4.
//  - Sub-module seg7_slot_timer: loadable down-counter with a terminal-count flag.
//    Counter width = clog2(max(SHOW_CYCLES,BLANK_CYCLES)).
//  - The top level contains the FSM, the idx counter, shadow/active registers and output decode.
//  - The existing seg7 decoder stays outside this block.
// TESTING (bench params: NUM_DIGITS=4, SHOW_CYCLES=8, BLANK_CYCLES=2)
//  1 Reset: assert rst, en=0.
//    -> digit_en=0000, seg_digit=0, wr_ready=1, frame_done=0.
//    Release rst -> values hold while en=0.
//  2 Idle write: wr_data=16'h4321, wr_dp=4'b0001, then en=1.
//    -> wr_ready is 0 for one cycle.
//    -> After 2 blank cycles: digit_en=0001, seg_digit=1, seg_dp=1 for 8 cycles.
//    -> Then 0000 for 2 cycles, then 0010/2, 0100/3, 1000/4.
//    -> frame_done pulses once per 40 cycles.
//  3 Mid-frame write 16'hABCD during digit 1.
//    -> wr_ready=0 until frame_done; digits 2 and 3 still show 3 and 4.
//    -> Next frame digit 0 shows D.
//    -> A second wr_valid held meanwhile is accepted on the cycle after the commit.
//  4 en=0 during SHOW of digit 2.
//    -> Next cycle digit_en=0000, no frame_done.
//    -> Re-enable -> restarts at digit 0 after 2 blank cycles.
//  5 rst pulsed between clock edges mid-SHOW.
//    -> digit_en=0000 and wr_ready=1 before the next edge; pending write is discarded.
//  6 NUM_DIGITS=1 build: digit_en=1 for 8 cycles, 0 for 2.
//    -> frame_done at every slot end; a pending write commits at the first slot end.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 digit scan logic.
package seg7_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_SHOW  = 2'd2
    } scan_state_t;

    // Index/counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter that measures blanking and show slots.
// o_tc is high while the count sits at zero.
module seg7_slot_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scans one frame of digit codes across NUM_DIGITS positions with blanking gaps,
// and double-buffers new frames so they are only committed at a frame boundary.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_CYCLES  = 10000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]        wr_data,
    input  logic [NUM_DIGITS-1:0]                wr_dp,
    output logic [DIGIT_W-1:0]                   seg_digit,
    output logic                                 seg_dp,
    output logic [NUM_DIGITS-1:0]                digit_en,
    output logic [clog2_min1(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                 frame_done
);

    localparam int unsigned IDX_W   = clog2_min1(NUM_DIGITS);
    localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned TMR_W   = clog2_min1(MAX_CYC);
    localparam int unsigned DATA_W  = DIGIT_W * NUM_DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] SHOW_LOAD  = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic                r_en;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;

    logic                w_tmr_clr;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_load_val;
    logic                w_tmr_tc;

    logic [DATA_W-1:0]     r_shadow_data;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic                  r_pending;
    logic [DATA_W-1:0]     r_active_data;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic [DIGIT_W-1:0]    r_seg_digit;
    logic                  r_seg_dp;

    logic                  w_seg_load;
    logic                  w_frame_end;
    logic                  w_capture;
    logic                  w_commit;
    logic [DIGIT_W-1:0]    w_sel_digit;
    logic                  w_sel_dp;
    logic [NUM_DIGITS-1:0] w_digit_en;

    seg7_slot_timer #(
        .CNT_W (TMR_W)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .o_tc       (w_tmr_tc)
    );

    // en is registered so the scan never has an input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_state <= SCAN_IDLE;
            r_idx   <= '0;
        end else begin
            r_en    <= en;
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tmr_clr      = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = BLANK_LOAD;
        w_seg_load     = 1'b0;
        if (!r_en) begin
            w_state_nxt = SCAN_IDLE;
            w_idx_nxt   = '0;
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                SCAN_IDLE: begin
                    w_state_nxt    = SCAN_BLANK;
                    w_idx_nxt      = '0;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = BLANK_LOAD;
                end
                SCAN_BLANK: begin
                    if (w_tmr_tc) begin
                        w_state_nxt    = SCAN_SHOW;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = SHOW_LOAD;
                        w_seg_load     = 1'b1;
                    end
                end
                SCAN_SHOW: begin
                    if (w_tmr_tc) begin
                        w_state_nxt    = SCAN_BLANK;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = BLANK_LOAD;
                        w_idx_nxt      = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = SCAN_IDLE;
                    w_idx_nxt   = '0;
                    w_tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    // Digit select and one-hot enable decode from the current index.
    always_comb begin
        w_sel_digit = '0;
        w_sel_dp    = 1'b0;
        w_digit_en  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_digit   = r_active_data[i*DIGIT_W +: DIGIT_W];
                w_sel_dp      = r_active_dp[i];
                w_digit_en[i] = (r_state == SCAN_SHOW);
            end
        end
    end

    assign w_frame_end = r_en && (r_state == SCAN_SHOW) && w_tmr_tc && (r_idx == LAST_IDX);
    assign w_capture   = wr_valid && !r_pending;
    assign w_commit    = r_pending && ((r_state == SCAN_IDLE) || w_frame_end);

    // Shadow/active frame buffers; capture and commit are mutually exclusive via r_pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pending     <= 1'b0;
            r_active_data <= '0;
            r_active_dp   <= '0;
        end else begin
            if (w_capture) begin
                r_shadow_data <= wr_data;
                r_shadow_dp   <= wr_dp;
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                r_active_data <= r_shadow_data;
                r_active_dp   <= r_shadow_dp;
                r_pending     <= 1'b0;
            end
        end
    end

    // Segment code is latched on slot entry and held through blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_digit <= '0;
            r_seg_dp    <= 1'b0;
        end else if (w_seg_load) begin
            r_seg_digit <= w_sel_digit;
            r_seg_dp    <= w_sel_dp;
        end
    end

    assign wr_ready   = !r_pending;
    assign seg_digit  = r_seg_digit;
    assign seg_dp     = r_seg_dp;
    assign digit_en   = w_digit_en;
    assign digit_idx  = r_idx;
    assign frame_done = w_frame_end;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Randomized and directed bench for seg7_scan_scheduler against a slot-arithmetic model.
module tb_seg7_scan_scheduler;

    localparam int N     = 4;
    localparam int S     = 8;
    localparam int B     = 2;
    localparam int P     = B + S;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  seg_digit;
    logic        seg_dp;
    logic [3:0]  digit_en;
    logic [1:0]  digit_idx;
    logic        frame_done;

    logic        en1;
    logic        wr_valid1;
    logic        wr_ready1;
    logic [3:0]  wr_data1;
    logic [0:0]  wr_dp1;
    logic [3:0]  seg_digit1;
    logic        seg_dp1;
    logic [0:0]  digit_en1;
    logic [0:0]  digit_idx1;
    logic        frame_done1;

    int checks = 0;
    int errors = 0;

    // Model: position m_p counts cycles since the first blanking cycle of a scan run.
    bit          m_running;
    int          m_p;
    bit          m_en_q;
    logic [15:0] m_active, m_shadow;
    logic [3:0]  m_active_dp, m_shadow_dp;
    bit          m_pending;
    bit          m_captured;
    logic [3:0]  m_seg;
    logic        m_dp;

    logic [12:0] obs;
    assign obs = {digit_en, seg_digit, seg_dp, frame_done, wr_ready, digit_idx};

    always #5 clk = ~clk;

    seg7_scan_scheduler #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .seg_digit(seg_digit), .seg_dp(seg_dp),
        .digit_en(digit_en), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    seg7_scan_scheduler #(.NUM_DIGITS(1), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .wr_data(wr_data1), .wr_dp(wr_dp1), .seg_digit(seg_digit1), .seg_dp(seg_dp1),
        .digit_en(digit_en1), .digit_idx(digit_idx1), .frame_done(frame_done1)
    );

    task automatic model_reset();
        m_running = 0; m_p = 0; m_en_q = 0;
        m_active = '0; m_shadow = '0; m_active_dp = '0; m_shadow_dp = '0;
        m_pending = 0; m_captured = 0; m_seg = '0; m_dp = 1'b0;
    endtask

    function automatic logic [12:0] exp_vec();
        logic [3:0] v_en;
        logic       v_fd;
        logic [1:0] v_ix;
        v_en = '0; v_fd = 1'b0; v_ix = '0;
        if (m_running) begin
            v_ix = 2'((m_p / P) % N);
            if ((m_p % P) >= B) begin
                v_en[(m_p / P) % N] = 1'b1;
                v_fd = m_en_q && ((m_p % FRAME) == FRAME - 1);
            end
        end
        return {v_en, m_seg, m_dp, v_fd, ~m_pending, v_ix};
    endfunction

    // One clock edge; advances the model using the inputs presented before the edge.
    task automatic tick();
        int ph, dg;
        bit fend, cap, com;
        ph   = m_p % P;
        dg   = (m_p / P) % N;
        fend = m_running && m_en_q && (ph >= B) && ((m_p % FRAME) == FRAME - 1);
        @(posedge clk);
        cap = wr_valid && !m_pending;
        com = m_pending && (!m_running || fend);
        if (m_running && m_en_q && ph == B - 1) begin
            m_seg = m_active[dg*4 +: 4];
            m_dp  = m_active_dp[dg];
        end
        if (com) begin
            m_active = m_shadow; m_active_dp = m_shadow_dp; m_pending = 0;
        end
        if (cap) begin
            m_shadow = wr_data; m_shadow_dp = wr_dp; m_pending = 1;
        end
        m_captured = cap;
        if (!m_en_q) begin
            m_running = 0; m_p = 0;
        end else if (!m_running) begin
            m_running = 1; m_p = 0;
        end else begin
            m_p++;
        end
        m_en_q = en;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
        en1 = 1'b0; wr_valid1 = 1'b0; wr_data1 = '0; wr_dp1 = '0;
        model_reset();
        #1;
        checks++;
        if (obs !== 13'b0000_0000_0_0_1_00) begin
            errors++; $display("FAIL reset_async got=%b exp=%b", obs, 13'b0000_0000_0_0_1_00);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_idle_write();
        int first_show, fd_cnt;
        wr_data = 16'h4321; wr_dp = 4'b0001; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL idle_write_busy got=%b exp=0", wr_ready); end
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_write_commit got=%b exp=1", wr_ready); end
        en = 1'b1;
        first_show = -1; fd_cnt = 0;
        for (int k = 1; k <= 2 * FRAME + 5; k++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL idle_write_scan k=%0d got=%b exp=%b", k, obs, exp_vec());
            end
            if (first_show < 0 && digit_en != 4'b0000) first_show = k;
            if (frame_done === 1'b1) fd_cnt++;
        end
        checks++;
        if (first_show !== 1 + B + 1) begin
            errors++; $display("FAIL idle_write_latency got=%0d exp=%0d", first_show, 1 + B + 1);
        end
        checks++;
        if (fd_cnt !== 2) begin errors++; $display("FAIL idle_write_frames got=%0d exp=2", fd_cnt); end
    endtask

    task automatic test_mid_frame_write();
        int fd_tick, cap_tick, k;
        bit seen_d;
        k = 0;
        while (!(m_running && (m_p % P) >= B && (m_p / P) % N == 1) && k < 200) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL mid_seek got=%b exp=%b", obs, exp_vec()); end
        end
        checks++;
        if (k >= 200) begin errors++; $display("FAIL mid_seek_timeout got=%0d exp=<200", k); end
        wr_data = 16'hABCD; wr_dp = 4'($urandom); wr_valid = 1'b1;
        tick();
        checks++;
        if (!m_captured || obs !== exp_vec()) begin
            errors++; $display("FAIL mid_accept got=%b exp=%b", obs, exp_vec());
        end
        wr_data = 16'($urandom); wr_dp = 4'($urandom);
        fd_tick = -1; cap_tick = -1; seen_d = 0;
        for (int t = 1; t < 3 * FRAME && !seen_d; t++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL mid_scan t=%0d got=%b exp=%b", t, obs, exp_vec());
            end
            if (fd_tick < 0 && frame_done === 1'b1) fd_tick = t;
            if (cap_tick < 0 && m_captured) begin cap_tick = t; wr_valid = 1'b0; end
            if (cap_tick > 0 && digit_en === 4'b0001) begin
                seen_d = 1;
                checks++;
                if (seg_digit !== 4'hD) begin
                    errors++; $display("FAIL mid_new_digit0 got=%h exp=d", seg_digit);
                end
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (fd_tick < 0 || cap_tick !== fd_tick + 2 || !seen_d) begin
            errors++; $display("FAIL mid_second_accept got=%0d exp=%0d", cap_tick, fd_tick + 2);
        end
    endtask

    task automatic test_disable();
        int k, fd_cnt;
        k = 0;
        while (!(m_running && (m_p % P) >= B + 3 && (m_p / P) % N == 2) && k < 200) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL dis_seek got=%b exp=%b", obs, exp_vec()); end
        end
        en = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL dis_off i=%0d got=%b exp=%b", i, obs, exp_vec());
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        checks++;
        if (digit_en !== 4'b0000 || fd_cnt !== 0) begin
            errors++; $display("FAIL dis_dark got=%b/%0d exp=0000/0", digit_en, fd_cnt);
        end
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL dis_restart i=%0d got=%b exp=%b", i, obs, exp_vec());
            end
            if (i == 1 + B + 1) begin
                checks++;
                if (digit_en !== 4'b0001) begin
                    errors++; $display("FAIL dis_restart_digit0 got=%b exp=0001", digit_en);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        k = 0;
        while (!(m_running && (m_p % P) >= B) && k < 50) begin tick(); k++; end
        wr_data = 16'h5A5A; wr_dp = 4'b1010; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0 || digit_en === 4'b0000) begin
            errors++; $display("FAIL arst_pre got=%b/%b exp=0/show", wr_ready, digit_en);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (digit_en !== 4'b0000 || wr_ready !== 1'b1 || seg_digit !== 4'h0) begin
            errors++; $display("FAIL arst_immediate got=%b/%b/%h exp=0000/1/0", digit_en, wr_ready, seg_digit);
        end
        en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL arst_after i=%0d got=%b exp=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        en = 1'b1; wr_valid = 1'b0; m_captured = 0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) < 2) en = ~en;
            if (!wr_valid || m_captured) begin
                wr_valid = ($urandom_range(0, 5) == 0);
                wr_data  = 16'($urandom);
                wr_dp    = 4'($urandom);
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_vec());
            end
        end
        wr_valid = 1'b0;
        en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single_digit();
        bit         pend1, run_pre, fd_pre, cap, com, x_en, x_fd;
        logic [3:0] sh1, act1, seg1;
        logic       shdp1, actdp1, dp1;
        int         p_pre, p, fd_cnt;
        pend1 = 0; sh1 = '0; act1 = '0; seg1 = '0; shdp1 = 0; actdp1 = 0; dp1 = 0; fd_cnt = 0;
        en1 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin wr_valid1 = 1'b1; wr_data1 = 4'h7; wr_dp1 = 1'b1; end
            p_pre   = k - 3;
            run_pre = (k - 1) >= 2;
            fd_pre  = run_pre && (p_pre % P) == P - 1;
            tick();
            cap = wr_valid1 && !pend1;
            com = pend1 && (!run_pre || fd_pre);
            if (run_pre && (p_pre % P) == B - 1) begin seg1 = act1; dp1 = actdp1; end
            if (com) begin act1 = sh1; actdp1 = shdp1; pend1 = 0; end
            if (cap) begin sh1 = wr_data1; shdp1 = wr_dp1[0]; pend1 = 1; wr_valid1 = 1'b0; end
            p    = k - 2;
            x_en = (k >= 2) && (p % P) >= B;
            x_fd = (k >= 2) && (p % P) == P - 1;
            if (frame_done1 === 1'b1) fd_cnt++;
            checks++;
            if ({digit_en1, frame_done1, wr_ready1, seg_digit1, seg_dp1, digit_idx1} !==
                {x_en, x_fd, ~pend1, seg1, dp1, 1'b0}) begin
                errors++;
                $display("FAIL single k=%0d got=%b%b%b_%h%b exp=%b%b%b_%h%b", k,
                         digit_en1, frame_done1, wr_ready1, seg_digit1, seg_dp1,
                         x_en, x_fd, ~pend1, seg1, dp1);
            end
        end
        checks++;
        if (fd_cnt !== 4 || seg_digit1 !== 4'h7) begin
            errors++; $display("FAIL single_summary got=%0d/%h exp=4/7", fd_cnt, seg_digit1);
        end
        en1 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_idle_write();
        test_mid_frame_write();
        test_disable();
        test_async_reset();
        test_random();
        test_single_digit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
